fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   NOP_INSTR        : word shown on instr_out when nothing is valid
//   DEFAULT_RESET_PC : default first fetch address
//   DEFAULT_PC_LIMIT : default first byte address beyond instruction memory
//   fetch_state_t    : fetch FSM states
//   fetch_entry_t    : prefetch queue payload {pc, instr}
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] DEFAULT_PC_LIMIT = 32'd400;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer of fetch entries, DEPTH a power of two.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the queue)
//   i_push     : write i_wdata at the tail (caller guarantees a free slot)
//   i_pop      : drop the head entry (caller guarantees non-empty)
//   i_flush    : discard every entry; overrides push and pop
//   o_rdata    : head entry
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : number of stored entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  fetch_entry_t                   i_wdata,
  output fetch_entry_t                   o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH + 1) - 1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t             r_mem [DEPTH];
  logic         [PTR_W-1:0] r_wr_ptr;
  logic         [PTR_W-1:0] r_rd_ptr;
  logic         [CNT_W-1:0] r_count;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^PTR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks pc through instruction memory, buffers
// {pc, instruction} pairs in a prefetch queue and hands them to decode
// with a valid/ready handshake. A taken branch flushes the queue and
// redirects pc. Fetching stops (DONE) once pc reaches PC_LIMIT.
// Optional feature macro: FETCH_BYPASS_EN -- when the queue is empty in RUN,
// the memory word is forwarded straight to decode in the same cycle.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   pc            : fetch address to the memory controller
//   instruction   : memory word for pc (combinational return)
//   branch_taken  : redirect request; branch_target is the new pc
//   instr_out     : instruction presented to decode
//   pc_out        : address of instr_out
//   instr_valid   : instr_out/pc_out valid
//   instr_ready   : decode accepts this cycle
//   fetch_done    : high in state DONE
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_LIMIT = DEFAULT_PC_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_done
);

  localparam int unsigned  CNT_W       = $clog2(DEPTH + 1);
  localparam fetch_state_t RESET_STATE = (RESET_PC >= PC_LIMIT) ? DONE : RUN;

  fetch_state_t       r_state;
  fetch_state_t       w_next_state;
  logic [31:0]        r_pc;
  logic [32:0]        w_pc_inc;
  logic               w_limit_hit;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_fifo_pop;
  logic               w_bypass;
  logic               w_bypass_take;
  logic               w_free;
  logic               w_no_slot;
  logic               w_fetch;
  logic               w_push;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_fifo_pop),
    .i_flush (branch_taken),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Queue-side pop: a branch cycle never consumes an entry.
  assign w_fifo_pop = instr_ready && !w_empty && !branch_taken;

`ifdef FETCH_BYPASS_EN
  // Empty queue in RUN forwards the memory word directly; gated by rst_n so
  // reset forces the outputs idle even though the state reads RUN.
  assign w_bypass = rst_n && w_empty && (r_state == RUN) && !branch_taken;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_take = w_bypass && instr_ready;

  // A slot is free when not full, or when full but the head leaves this cycle.
  assign w_free    = !w_full || w_fifo_pop;
  assign w_no_slot = (w_count == CNT_W'(DEPTH)) && !w_fifo_pop;

  // The current word is consumed (queued or bypassed) and pc advances.
  assign w_fetch = (r_state != DONE) && (r_pc < PC_LIMIT) && w_free && !branch_taken;
  assign w_push  = w_fetch && !w_bypass_take;

  // 33-bit add so a limit near the top of the address space cannot wrap.
  assign w_pc_inc    = {1'b0, r_pc} + 33'd4;
  assign w_limit_hit = (w_pc_inc >= {1'b0, PC_LIMIT});

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = instruction;

  assign pc = r_pc;

  // Fetch address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= branch_target;
    end else if (w_fetch) begin
      r_pc <= w_pc_inc[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a redirect overrides everything.
  always_comb begin
    w_next_state = r_state;
    if (branch_taken) begin
      w_next_state = (branch_target >= PC_LIMIT) ? DONE : RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_fetch && w_limit_hit) w_next_state = DONE;
          else if (w_no_slot)         w_next_state = HOLD;
        end
        HOLD: begin
          if (w_fetch && w_limit_hit) w_next_state = DONE;
          else if (w_fifo_pop)        w_next_state = RUN;
        end
        DONE:    w_next_state = DONE;
        default: w_next_state = RUN;
      endcase
    end
  end

  // FSM output logic: queue head first, bypass only when the queue is empty.
  always_comb begin
    instr_valid = 1'b0;
    instr_out   = NOP_INSTR;
    pc_out      = 32'd0;
    fetch_done  = rst_n && (r_state == DONE);
    if (!w_empty && !branch_taken) begin
      instr_valid = 1'b1;
      instr_out   = w_head.instr;
      pc_out      = w_head.pc;
    end else if (w_bypass) begin
      instr_valid = 1'b1;
      instr_out   = instruction;
      pc_out      = r_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns pc + 0x1000 (or a NOP at a
// chosen address); expected values are hand-derived per scenario.
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_done;
  logic [31:0] nop_pc;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .instruction   (instruction),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .fetch_done    (fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = (pc == nop_pc) ? NOP_INSTR : (pc + 32'h1000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset pulse mid-cycle, then release on a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_rst_count"}, 32'(dut.w_count), 32'd0);
    check({tag, "_rst_pc"},    pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] last_pc;
    logic        drained;

    rst_n         = 1'b0;
    instr_ready   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    nop_pc        = 32'hFFFF_FFF0;

    // Reset values
    #1;
    check("rst_valid",   32'(instr_valid), 32'd0);
    check("rst_instr",   instr_out, NOP_INSTR);
    check("rst_pc_out",  pc_out, 32'd0);
    check("rst_done",    32'(fetch_done), 32'd0);
    check("rst_pc",      pc, 32'd0);
    check("rst_state",   32'(dut.r_state), 32'(RUN));

    // Streaming from reset release with decode always ready
    #21;
    rst_n = 1'b1;
    #1;
    check("t1_pre_valid", 32'(instr_valid), BYP);
    if (BYP == 32'd1) check("t1_pre_pc_out", pc_out, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_valid",  32'(instr_valid), 32'd1);
      check("t1_pc_out", pc_out, 32'(4 * (k + int'(BYP))));
      check("t1_instr",  instr_out, 32'(4 * (k + int'(BYP))) + 32'h1000);
    end

    // Decode stalled: queue fills and the FSM holds
    instr_ready = 1'b0;
    do_reset("t2");
    for (int k = 0; k < 10; k++) tick();
    check("t2_count",  32'(dut.w_count), 32'd4);
    check("t2_state",  32'(dut.r_state), 32'(HOLD));
    check("t2_pc",     pc, 32'd16);
    check("t2_head",   pc_out, 32'd0);
    instr_ready = 1'b1;
    #1;
    check("t2_pop_pc", pc_out, 32'd0);
    tick();
    instr_ready = 1'b0;
    #1;
    check("t2_pc_after", pc, 32'd20);
    check("t2_count_after", 32'(dut.w_count), 32'd4);
    check("t2_next_head", pc_out, 32'd4);

    // Branch flush with three entries queued
    do_reset("t3");
    for (int k = 0; k < 3; k++) tick();
    check("t3_count", 32'(dut.w_count), 32'd3);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #1;
    check("t3_br_valid", 32'(instr_valid), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("t3_count0", 32'(dut.w_count), 32'd0);
    check("t3_pc",     pc, 32'h40);
    check("t3_valid_empty", 32'(instr_valid), BYP);
    tick();
    check("t3_first_pc",    pc_out, 32'h40);
    check("t3_first_instr", instr_out, 32'h1040);
    // Unaligned target passes through untouched; NOP words are queued
    branch_taken  = 1'b1;
    branch_target = 32'h42;
    tick();
    branch_taken = 1'b0;
    nop_pc       = 32'h46;
    #1;
    check("t3_unaligned_pc", pc, 32'h42);
    tick();
    tick();
    check("t3_nop_count", 32'(dut.w_count), 32'd2);
    instr_ready = 1'b1;
    #1;
    check("t3_head_42", pc_out, 32'h42);
    tick();
    check("t3_nop_pc",    pc_out, 32'h46);
    check("t3_nop_instr", instr_out, NOP_INSTR);
    instr_ready = 1'b0;
    nop_pc      = 32'hFFFF_FFF0;

    // Free run to the end of instruction memory
    instr_ready = 1'b1;
    do_reset("t4");
    last_pc = 32'hDEAD_BEEF;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      tick();
      if (instr_valid) last_pc = pc_out;
      if (fetch_done && !instr_valid) drained = 1'b1;
    end
    check("t4_drained", 32'(drained), 32'd1);
    check("t4_last_pc", last_pc, 32'd396);
    check("t4_done",    32'(fetch_done), 32'd1);
    check("t4_pc",      pc, 32'd400);
    check("t4_count",   32'(dut.w_count), 32'd0);
    for (int k = 0; k < 3; k++) tick();
    check("t4_pc_held", pc, 32'd400);
    check("t4_idle",    32'(instr_valid), 32'd0);

    // Branch to the limit enters DONE with an empty queue
    instr_ready = 1'b0;
    do_reset("t5");
    tick();
    tick();
    check("t5_count2", 32'(dut.w_count), 32'd2);
    check("t5_not_done", 32'(fetch_done), 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'd400;
    #1;
    check("t5_br_valid", 32'(instr_valid), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("t5_done",  32'(fetch_done), 32'd1);
    check("t5_count", 32'(dut.w_count), 32'd0);
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_pc",    pc, 32'd400);
    tick();
    check("t5_state", 32'(dut.r_state), 32'(DONE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
